// File: rtl/genie_rr_merge_arb.sv
// Round-robin merge arbiter with packet lock; steers genie_mux through a binary select.
// Grant, select, valid/eop and ready are combinational (zero-latency arbitration).
//
// state   | meaning
// --------+-----------------------------------------------------------
// ST_IDLE | no packet in flight; arbitrate from r_ptr+1 each cycle
// ST_LOCK | packet in flight from r_lk; grant held until eop transfers
module genie_rr_merge_arb #(
    parameter int NI = 4,
    parameter int WS = 2
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic [NI-1:0] i_valid,
    input  logic [NI-1:0] i_eop,
    output logic [NI-1:0] i_ready,
    output logic          o_valid,
    output logic          o_eop,
    input  logic          o_ready,
    output logic [WS-1:0] sel,
    output logic [NI-1:0] grant
);

    typedef enum logic {ST_IDLE, ST_LOCK} state_t;

    state_t        r_st;
    logic [WS-1:0] r_ptr;
    logic [WS-1:0] r_lk;

    logic          w_found;
    logic [WS-1:0] w_win;
    logic [WS-1:0] w_cur;
    logic          w_act;
    logic          w_vld;
    logic          w_eop;
    logic          w_xfer;

    // Wrap by compare-and-subtract so non-power-of-two NI never yields an index >= NI.
    always_comb begin : rr_search
        int idx;
        idx     = 0;
        w_found = 1'b0;
        w_win   = r_ptr;
        for (int k = 1; k <= NI; k++) begin
            idx = int'(r_ptr) + k;
            if (idx >= NI) begin
                idx = idx - NI;
            end
            if (!w_found && i_valid[WS'(idx)]) begin
                w_found = 1'b1;
                w_win   = WS'(idx);
            end
        end
    end

    always_comb begin
        w_act  = (r_st == ST_LOCK) || w_found;
        w_cur  = (r_st == ST_LOCK) ? r_lk : w_win;
        w_vld  = (r_st == ST_LOCK) ? i_valid[r_lk] : w_found;
        w_eop  = w_act && i_eop[w_cur];
        w_xfer = w_vld && o_ready;
    end

    // Outputs are gated by reset_n so they drop to zero the moment reset asserts.
    always_comb begin
        grant   = '0;
        i_ready = '0;
        sel     = '0;
        o_valid = 1'b0;
        o_eop   = 1'b0;
        if (reset_n) begin
            sel     = w_cur;
            o_valid = w_vld;
            o_eop   = w_eop;
            if (w_act) begin
                grant   = NI'(1) << w_cur;
                i_ready = o_ready ? (NI'(1) << w_cur) : '0;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_st  <= ST_IDLE;
            r_ptr <= WS'(NI - 1);
            r_lk  <= '0;
        end else begin
            unique case (r_st)
                ST_IDLE: begin
                    if (w_xfer) begin
                        if (w_eop) begin
                            r_ptr <= w_win;
                        end else begin
                            r_lk <= w_win;
                            r_st <= ST_LOCK;
                        end
                    end
                end
                ST_LOCK: begin
                    if (w_xfer && w_eop) begin
                        r_ptr <= r_lk;
                        r_st  <= ST_IDLE;
                    end
                end
                default: r_st <= ST_IDLE;
            endcase
        end
    end

endmodule
